// File: rtl/noc_pkg.sv
// Shared NoC types: flit width, port numbering and crossbar output-arbiter states.
package noc_pkg;
  localparam int FLIT_W    = 16;
  localparam int NUM_PORTS = 5;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_W = 3'd2,
    PORT_E = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } xbar_arb_state_e;
endpackage

// File: rtl/xbar_out_port_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request scanning upward from ptr with wrap.
// Zero latency; no state, so backpressure is handled entirely by the caller.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter  int NUM_IN = NUM_PORTS,
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any_gnt
);

  logic [SEL_W-1:0] w_k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    w_k     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_k = SEL_W'((int'(ptr) + i) % NUM_IN);
      if (!any_gnt && req[w_k]) begin
        gnt[w_k] = 1'b1;
        gnt_idx  = w_k;
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbar_out_port_arb.sv
// Crossbar output port: round-robin NUM_IN:1 flit select with wormhole lock and a registered output.
// Accepted flit appears 1 cycle later; inputs stall whenever the output register is full and not draining.
module xbar_out_port_arb
  import noc_pkg::*;
#(
  parameter  int DATA_W = FLIT_W,
  parameter  int NUM_IN = NUM_PORTS,
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_IN-1:0]             in_valid_i,
  input  logic [NUM_IN-1:0][DATA_W-1:0] in_data_i,
  input  logic [NUM_IN-1:0]             in_tail_i,
  output logic [NUM_IN-1:0]             in_ready_o,
  output logic                          out_valid_o,
  output logic [DATA_W-1:0]             out_data_o,
  output logic                          out_tail_o,
  input  logic                          out_ready_i,
  output logic [SEL_W-1:0]              grant_o,
  output logic                          busy_o
);

  xbar_arb_state_e   r_state;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic [SEL_W-1:0]  r_owner;
  logic [SEL_W-1:0]  r_grant;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_tail;

  logic              w_ld;
  logic              w_acc;
  logic              w_any;
  logic              w_sel_tail;
  logic [NUM_IN-1:0] w_arb_gnt;
  logic [NUM_IN-1:0] w_own_oh;
  logic [NUM_IN-1:0] w_rdy;
  logic [SEL_W-1:0]  w_arb_idx;
  logic [SEL_W-1:0]  w_sel;
  logic [SEL_W-1:0]  w_next_ptr;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_rr_arbiter (
    .req     (in_valid_i),
    .ptr     (r_rr_ptr),
    .gnt     (w_arb_gnt),
    .gnt_idx (w_arb_idx),
    .any_gnt (w_any)
  );

  assign w_ld = !r_out_valid || out_ready_i;

  always_comb begin
    w_own_oh          = '0;
    w_own_oh[r_owner] = 1'b1;
  end

  // While locked, the arbiter result is ignored; only the packet owner may advance.
  always_comb begin
    w_rdy = '0;
    if (!rst_i && w_ld) begin
      if (r_state == ARB_LOCKED) w_rdy = w_own_oh & in_valid_i;
      else if (w_any)            w_rdy = w_arb_gnt;
    end
  end

  assign in_ready_o = w_rdy;
  assign w_acc      = |w_rdy;
  assign w_sel      = (r_state == ARB_LOCKED) ? r_owner : w_arb_idx;
  assign w_sel_tail = in_tail_i[w_sel];
  assign w_next_ptr = (w_sel == SEL_W'(NUM_IN - 1)) ? '0 : w_sel + SEL_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tail  <= 1'b0;
    end else begin
      if (w_ld) begin
        r_out_valid <= w_acc;
        if (w_acc) begin
          r_out_data <= in_data_i[w_sel];
          r_out_tail <= w_sel_tail;
        end
      end
      if (w_acc) begin
        r_grant <= w_sel;
        case (r_state)
          ARB_IDLE: begin
            if (w_sel_tail) begin
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_state <= ARB_LOCKED;
              r_owner <= w_sel;
            end
          end
          ARB_LOCKED: begin
            if (w_sel_tail) begin
              r_state  <= ARB_IDLE;
              r_rr_ptr <= w_next_ptr;
            end
          end
          default: r_state <= ARB_IDLE;
        endcase
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_tail_o  = r_out_tail;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state == ARB_LOCKED);

endmodule

// File: tb/tb_xbar_out_port_arb.sv
// Scoreboarded bench: per-input packet queues feed the DUT; a packet-level model predicts acceptance.
module tb_xbar_out_port_arb;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [4:0]      in_valid_i;
  logic [4:0][15:0] in_data_i;
  logic [4:0]      in_tail_i;
  logic [4:0]      in_ready_o;
  logic            out_valid_o;
  logic [15:0]     out_data_o;
  logic            out_tail_o;
  logic            out_ready_i;
  logic [2:0]      grant_o;
  logic            busy_o;

  always #5 clk = ~clk;

  xbar_out_port_arb #(.DATA_W(16), .NUM_IN(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_tail_i   (in_tail_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_tail_o  (out_tail_o),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Pending flits per input as {tail, data}; expected output flits as {src, tail, data}.
  logic [16:0] inq [5][$];
  logic [19:0] expq[$];
  int owner   = -1;
  int rr      = 0;
  int vld_pct = 100;
  int rdy_pct = 100;
  bit refill  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_flit(input int p, input logic [15:0] d, input logic t);
    inq[p].push_back({t, d});
  endtask

  task automatic add_pkt(input int p, input int len);
    for (int j = 0; j < len; j++) inq[p].push_back({(j == len - 1), 16'($urandom)});
  endtask

  task automatic step(input bit rst);
    int w;
    int idx;
    logic ld;
    logic [16:0] f;
    @(negedge clk);
    if (refill)
      for (int i = 0; i < 5; i++)
        if (inq[i].size() == 0 && $urandom_range(0, 2) == 0) add_pkt(i, $urandom_range(1, 3));
    rst_i       = rst;
    out_ready_i = !rst && ($urandom_range(0, 99) < rdy_pct);
    for (int i = 0; i < 5; i++) begin
      if (inq[i].size() > 0) begin
        in_valid_i[i] = rst || ($urandom_range(0, 99) < vld_pct);
        in_data_i[i]  = inq[i][0][15:0];
        in_tail_i[i]  = inq[i][0][16];
      end else begin
        in_valid_i[i] = rst;
        in_data_i[i]  = 16'($urandom);
        in_tail_i[i]  = 1'($urandom);
      end
    end
    #1;
    if (rst) begin
      chk("ready_in_reset", 32'(in_ready_o), 32'd0);
      expq.delete();
      for (int i = 0; i < 5; i++) inq[i].delete();
      owner = -1;
      rr    = 0;
      return;
    end
    chk("out_valid", 32'(out_valid_o), 32'(expq.size() > 0));
    chk("busy", 32'(busy_o), 32'(owner >= 0));
    ld = (expq.size() == 0) || out_ready_i;
    w  = -1;
    if (ld) begin
      if (owner >= 0) begin
        if (in_valid_i[owner]) w = owner;
      end else begin
        for (int k = 0; k < 5; k++) begin
          idx = (rr + k) % 5;
          if (w < 0 && in_valid_i[idx]) w = idx;
        end
      end
    end
    chk("in_ready", 32'(in_ready_o), (w >= 0) ? (32'd1 << w) : 32'd0);
    if (w >= 0) begin
      f = inq[w].pop_front();
      expq.push_back({3'(w), f});
      if (f[16]) begin
        owner = -1;
        rr    = (w + 1) % 5;
      end else begin
        owner = w;
      end
    end
  endtask

  // Monitor: whenever the output holds a flit, it must match the oldest expected flit.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_i !== 1'b1 && out_valid_o === 1'b1) begin
        if (expq.size() == 0) begin
          chk("out_unexpected", 32'(expq.size()), 32'd1);
        end else begin
          e = expq[0];
          chk("out_data", 32'(out_data_o), 32'(e[15:0]));
          chk("out_tail", 32'(out_tail_o), 32'(e[16]));
          chk("grant", 32'(grant_o), 32'(e[19:17]));
          if (out_ready_i) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    int pending;
    rst_i       = 1'b1;
    in_valid_i  = '0;
    in_data_i   = '0;
    in_tail_i   = '0;
    out_ready_i = 1'b0;

    step(1'b1);
    step(1'b1);
    step(1'b0);
    chk("grant_after_reset", 32'(grant_o), 32'd0);

    add_flit(0, 16'hA5A5, 1'b1);
    repeat (3) step(1'b0);

    for (int i = 0; i < 5; i++) begin
      add_flit(i, 16'(16'h1000 + i), 1'b1);
      add_flit(i, 16'(16'h2000 + i), 1'b1);
    end
    repeat (13) step(1'b0);

    step(1'b1);
    add_flit(1, 16'h1111, 1'b0);
    add_flit(1, 16'h2222, 1'b0);
    add_flit(1, 16'h3333, 1'b1);
    add_flit(3, 16'h4444, 1'b1);
    repeat (6) step(1'b0);

    add_pkt(2, 3);
    step(1'b0);
    rdy_pct = 0;
    repeat (3) step(1'b0);
    rdy_pct = 100;
    repeat (5) step(1'b0);

    add_pkt(4, 3);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    add_flit(4, 16'hBEEF, 1'b1);
    add_flit(0, 16'hCAFE, 1'b1);
    step(1'b0);
    chk("grant_after_midpkt_reset", 32'(grant_o), 32'd0);
    repeat (3) step(1'b0);

    refill = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        vld_pct = $urandom_range(50, 100);
        rdy_pct = $urandom_range(30, 100);
      end
      step($urandom_range(0, 499) == 0);
    end

    refill  = 1'b0;
    vld_pct = 100;
    rdy_pct = 100;
    for (int c = 0; c < 60; c++) step(1'b0);
    pending = expq.size();
    for (int i = 0; i < 5; i++) pending += inq[i].size();
    chk("drained", 32'(pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
